// File: rtl/sched_pkg.sv
// Shared types for the command scheduler: command encoding, class priority
// ordering and default timer width.
package sched_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_t;

  // Higher encoding wins; CLS_NONE means nothing eligible this cycle.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_PRE  = 3'd1,
    CLS_ACT  = 3'd2,
    CLS_COL  = 3'd3,
    CLS_REF  = 3'd4
  } cls_t;

  localparam int TMR_W_DEF     = 8;
  localparam int NUM_BANKS_DEF = 4;

endpackage

// File: rtl/sched_cmd_arbiter_chk.sv
// Simulation checks on the scheduler handshake: one request type per bank and
// at most one grant overall.
module sched_cmd_arbiter_chk #(
  parameter int NUM_BANKS = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_BANKS-1:0] act_req,
  input logic [NUM_BANKS-1:0] rd_req,
  input logic [NUM_BANKS-1:0] wr_req,
  input logic [NUM_BANKS-1:0] pre_req,
  input logic [NUM_BANKS-1:0] ref_req,
  input logic [NUM_BANKS-1:0] act_gnt,
  input logic [NUM_BANKS-1:0] rd_gnt,
  input logic [NUM_BANKS-1:0] wr_gnt,
  input logic [NUM_BANKS-1:0] pre_gnt,
  input logic [NUM_BANKS-1:0] ref_gnt
);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : gen_bank
    a_one_req_type: assert property (@(posedge clk) disable iff (rst)
      $onehot0({act_req[i], rd_req[i], wr_req[i], pre_req[i], ref_req[i]}));
  end

  a_gnt_onehot0: assert property (@(posedge clk)
    $onehot0({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}));

endmodule

// File: rtl/sched_rr_arb.sv
// Round-robin pick of one bank from a request vector, searching upward from
// the shared pointer and wrapping.
module sched_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // First requesting bank at or after the pointer takes the grant
  always_comb begin
    o_gnt   = {N{1'b0}};
    w_found = 1'b0;
    w_idx   = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      w_idx        = i_ptr + IDX_W'(k);
      o_gnt[w_idx] = i_req[w_idx] & ~w_found;
      w_found      = w_found | i_req[w_idx];
    end
  end

endmodule

// File: rtl/sched_cmd_arbiter.sv
// Grants at most one bank command per cycle under class priority, shared
// round-robin and inter-bank timers; issues the winner one cycle later.
module sched_cmd_arbiter
  import sched_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int BA_W      = $clog2(NUM_BANKS),
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int TMR_W     = TMR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BANKS-1:0]       act_req,
  input  logic [NUM_BANKS-1:0]       rd_req,
  input  logic [NUM_BANKS-1:0]       wr_req,
  input  logic [NUM_BANKS-1:0]       pre_req,
  input  logic [NUM_BANKS-1:0]       ref_req,
  output logic [NUM_BANKS-1:0]       act_gnt,
  output logic [NUM_BANKS-1:0]       rd_gnt,
  output logic [NUM_BANKS-1:0]       wr_gnt,
  output logic [NUM_BANKS-1:0]       pre_gnt,
  output logic [NUM_BANKS-1:0]       ref_gnt,
  input  logic [NUM_BANKS*RA_W-1:0]  ra_i,
  input  logic [NUM_BANKS*CA_W-1:0]  ca_i,
  input  logic [NUM_BANKS*ID_W-1:0]  id_i,
  input  logic [NUM_BANKS*LEN_W-1:0] len_i,
  input  logic [TMR_W-1:0]           t_rrd_m1,
  input  logic [TMR_W-1:0]           t_ccd_m1,
  input  logic [TMR_W-1:0]           t_wtr_m1,
  input  logic [TMR_W-1:0]           t_rtw_m1,
  input  logic [3:0]                 dfi_wren_lat,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_type,
  output logic [BA_W-1:0]            cmd_ba,
  output logic [RA_W-1:0]            cmd_ra,
  output logic [CA_W-1:0]            cmd_ca,
  output logic [ID_W-1:0]            cmd_id,
  output logic [LEN_W-1:0]           cmd_len
);

  logic [TMR_W-1:0]     r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [BA_W-1:0]      r_ptr;
  logic                 r_cmd_valid;
  logic [2:0]           r_cmd_type;
  logic [BA_W-1:0]      r_cmd_ba;
  logic [RA_W-1:0]      r_cmd_ra;
  logic [CA_W-1:0]      r_cmd_ca;
  logic [ID_W-1:0]      r_cmd_id;
  logic [LEN_W-1:0]     r_cmd_len;

  logic                 w_act_ok, w_rd_ok, w_wr_ok;
  logic [NUM_BANKS-1:0] w_rd_elig, w_wr_elig, w_act_elig, w_col_elig;
  logic [NUM_BANKS-1:0] w_ref_arb, w_col_arb, w_act_arb, w_pre_arb;
  logic [NUM_BANKS-1:0] w_sel;
  logic [BA_W-1:0]      w_idx;
  logic                 w_any;
  cls_t                 w_cls;
  cmd_t                 w_cmd;
  logic [TMR_W:0]       w_wtr_sum;
  logic [TMR_W-1:0]     w_wtr_load;

  function automatic logic [TMR_W-1:0] f_dec(input logic [TMR_W-1:0] v);
    return (v == {TMR_W{1'b0}}) ? v : v - TMR_W'(1);
  endfunction

  assign w_act_ok   = (r_rrd_cnt == {TMR_W{1'b0}});
  assign w_rd_ok    = (r_ccd_cnt == {TMR_W{1'b0}}) && (r_wtr_cnt == {TMR_W{1'b0}});
  assign w_wr_ok    = (r_ccd_cnt == {TMR_W{1'b0}}) && (r_rtw_cnt == {TMR_W{1'b0}});
  assign w_rd_elig  = rd_req  & {NUM_BANKS{w_rd_ok}};
  assign w_wr_elig  = wr_req  & {NUM_BANKS{w_wr_ok}};
  assign w_act_elig = act_req & {NUM_BANKS{w_act_ok}};
  // RD and WR share one column class so they round-robin against each other
  assign w_col_elig = w_rd_elig | w_wr_elig;

  assign w_wtr_sum  = {1'b0, t_wtr_m1} + {{(TMR_W-3){1'b0}}, dfi_wren_lat};
  assign w_wtr_load = w_wtr_sum[TMR_W] ? {TMR_W{1'b1}} : w_wtr_sum[TMR_W-1:0];

  sched_rr_arb #(.N(NUM_BANKS), .IDX_W(BA_W)) u_arb_ref (
    .i_req(ref_req), .i_ptr(r_ptr), .o_gnt(w_ref_arb));
  sched_rr_arb #(.N(NUM_BANKS), .IDX_W(BA_W)) u_arb_col (
    .i_req(w_col_elig), .i_ptr(r_ptr), .o_gnt(w_col_arb));
  sched_rr_arb #(.N(NUM_BANKS), .IDX_W(BA_W)) u_arb_act (
    .i_req(w_act_elig), .i_ptr(r_ptr), .o_gnt(w_act_arb));
  sched_rr_arb #(.N(NUM_BANKS), .IDX_W(BA_W)) u_arb_pre (
    .i_req(pre_req), .i_ptr(r_ptr), .o_gnt(w_pre_arb));

  // Highest non-empty eligible class wins; nothing is granted under reset
  always_comb begin
    w_cls = CLS_NONE;
    if (rst) begin
      w_cls = CLS_NONE;
    end else if (|w_ref_arb) begin
      w_cls = CLS_REF;
    end else if (|w_col_arb) begin
      w_cls = CLS_COL;
    end else if (|w_act_arb) begin
      w_cls = CLS_ACT;
    end else if (|w_pre_arb) begin
      w_cls = CLS_PRE;
    end else begin
      w_cls = CLS_NONE;
    end
  end

  // Route the winning class's pick onto its grant vector and command code
  always_comb begin
    act_gnt = {NUM_BANKS{1'b0}};
    rd_gnt  = {NUM_BANKS{1'b0}};
    wr_gnt  = {NUM_BANKS{1'b0}};
    pre_gnt = {NUM_BANKS{1'b0}};
    ref_gnt = {NUM_BANKS{1'b0}};
    w_sel   = {NUM_BANKS{1'b0}};
    w_cmd   = NOP;
    case (w_cls)
      CLS_REF: begin
        ref_gnt = w_ref_arb;
        w_sel   = w_ref_arb;
        w_cmd   = REF;
      end
      CLS_COL: begin
        rd_gnt = w_col_arb & w_rd_elig;
        wr_gnt = w_col_arb & w_wr_elig & ~w_rd_elig;
        w_sel  = w_col_arb;
        w_cmd  = (|(w_col_arb & w_rd_elig)) ? RD : WR;
      end
      CLS_ACT: begin
        act_gnt = w_act_arb;
        w_sel   = w_act_arb;
        w_cmd   = ACT;
      end
      CLS_PRE: begin
        pre_gnt = w_pre_arb;
        w_sel   = w_pre_arb;
        w_cmd   = PRE;
      end
      default: begin
        w_sel = {NUM_BANKS{1'b0}};
        w_cmd = NOP;
      end
    endcase
  end

  // Onehot grant to bank index
  always_comb begin
    w_idx = {BA_W{1'b0}};
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_idx = w_idx | (w_sel[k] ? BA_W'(k) : {BA_W{1'b0}});
    end
  end

  assign w_any = |w_sel;

  // Round-robin pointer advances past the granted bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {BA_W{1'b0}};
    end else if (w_any) begin
      r_ptr <= w_idx + BA_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Inter-bank timers: load on grant, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrd_cnt <= {TMR_W{1'b0}};
      r_ccd_cnt <= {TMR_W{1'b0}};
      r_wtr_cnt <= {TMR_W{1'b0}};
      r_rtw_cnt <= {TMR_W{1'b0}};
    end else begin
      r_rrd_cnt <= (|act_gnt) ? t_rrd_m1 : f_dec(r_rrd_cnt);
      r_ccd_cnt <= (|rd_gnt || |wr_gnt) ? t_ccd_m1 : f_dec(r_ccd_cnt);
      r_rtw_cnt <= (|rd_gnt) ? t_rtw_m1 : f_dec(r_rtw_cnt);
      r_wtr_cnt <= (|wr_gnt) ? w_wtr_load : f_dec(r_wtr_cnt);
    end
  end

  // Issue register toward the DFI command path
  always_ff @(posedge clk) begin
    if (rst || !w_any) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= NOP;
      r_cmd_ba    <= {BA_W{1'b0}};
      r_cmd_ra    <= {RA_W{1'b0}};
      r_cmd_ca    <= {CA_W{1'b0}};
      r_cmd_id    <= {ID_W{1'b0}};
      r_cmd_len   <= {LEN_W{1'b0}};
    end else begin
      r_cmd_valid <= 1'b1;
      r_cmd_type  <= w_cmd;
      r_cmd_ba    <= w_idx;
      r_cmd_ra    <= ra_i[w_idx*RA_W +: RA_W];
      r_cmd_ca    <= ca_i[w_idx*CA_W +: CA_W];
      r_cmd_id    <= id_i[w_idx*ID_W +: ID_W];
      r_cmd_len   <= len_i[w_idx*LEN_W +: LEN_W];
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_type  = r_cmd_type;
  assign cmd_ba    = r_cmd_ba;
  assign cmd_ra    = r_cmd_ra;
  assign cmd_ca    = r_cmd_ca;
  assign cmd_id    = r_cmd_id;
  assign cmd_len   = r_cmd_len;

  sched_cmd_arbiter_chk #(.NUM_BANKS(NUM_BANKS)) u_chk (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
    .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .pre_gnt(pre_gnt), .ref_gnt(ref_gnt));

endmodule

// File: tb/tb_sched_cmd_arbiter.sv
// Directed bench for sched_cmd_arbiter: a per-cycle vector table for priority
// and round-robin, plus hand sequences for timer spacing and reset.
module tb_sched_cmd_arbiter;

  localparam int NB = 4, BA_W = 2, RA_W = 16, CA_W = 10, ID_W = 4, LEN_W = 8, TMR_W = 8;
  localparam logic [2:0] T_NOP = 3'd0, T_ACT = 3'd1, T_RD = 3'd2, T_WR = 3'd3,
                         T_PRE = 3'd4, T_REF = 3'd5;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [NB*RA_W-1:0] ra_i;
  logic [NB*CA_W-1:0] ca_i;
  logic [NB*ID_W-1:0] id_i;
  logic [NB*LEN_W-1:0] len_i;
  logic [TMR_W-1:0] t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [3:0] dfi_wren_lat;
  logic cmd_valid;
  logic [2:0] cmd_type;
  logic [BA_W-1:0] cmd_ba;
  logic [RA_W-1:0] cmd_ra;
  logic [CA_W-1:0] cmd_ca;
  logic [ID_W-1:0] cmd_id;
  logic [LEN_W-1:0] cmd_len;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sched_cmd_arbiter #(.NUM_BANKS(NB), .BA_W(BA_W), .RA_W(RA_W), .CA_W(CA_W),
                      .ID_W(ID_W), .LEN_W(LEN_W), .TMR_W(TMR_W)) dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .dfi_wren_lat(dfi_wren_lat),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
    .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len));

  typedef struct packed {
    logic [3:0] act, rd, wr, pre, rf;
    logic [3:0] e_act, e_rd, e_wr, e_pre, e_rf;
    logic       e_v;
    logic [2:0] e_t;
    logic [1:0] e_ba;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    act_req = 4'b0; rd_req = 4'b0; wr_req = 4'b0; pre_req = 4'b0; ref_req = 4'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] exp_fields(input logic v, input logic [1:0] ba);
    logic [RA_W-1:0] ra;
    logic [CA_W-1:0] ca;
    logic [ID_W-1:0] id;
    logic [LEN_W-1:0] ln;
    ra = v ? (16'hA000 + {14'b0, ba}) : 16'h0;
    ca = v ? (10'h100 + {8'b0, ba}) : 10'h0;
    id = v ? (4'h4 + {2'b0, ba}) : 4'h0;
    ln = v ? (8'h10 + {6'b0, ba}) : 8'h0;
    return {26'b0, ra, ca, id, ln};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g, gw, gr;
    int nact, last, wrc, rdc;

    for (int i = 0; i < NB; i++) begin
      ra_i[i*RA_W +: RA_W]    = 16'hA000 + 16'(i);
      ca_i[i*CA_W +: CA_W]    = 10'h100 + 10'(i);
      id_i[i*ID_W +: ID_W]    = 4'h4 + 4'(i);
      len_i[i*LEN_W +: LEN_W] = 8'h10 + 8'(i);
    end
    t_rrd_m1 = 8'd0; t_ccd_m1 = 8'd0; t_wtr_m1 = 8'd0; t_rtw_m1 = 8'd0;
    dfi_wren_lat = 4'd0;

    //            act      rd       wr       pre      rf       e_act    e_rd     e_wr     e_pre    e_rf     v     type   ba
    vecs[0]  = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, T_NOP, 2'd0};
    vecs[1]  = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_REF, 2'd3};
    vecs[2]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_RD,  2'd2};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, T_ACT, 2'd1};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_PRE, 2'd0};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, T_NOP, 2'd0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, T_NOP, 2'd0};
    vecs[7]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_ACT, 2'd1};
    vecs[8]  = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_ACT, 2'd2};
    vecs[9]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_ACT, 2'd3};
    vecs[10] = '{4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_ACT, 2'd0};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, T_RD,  2'd2};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, T_WR,  2'd0};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, T_REF, 2'd1};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, T_PRE, 2'd2};

    // Reset held three cycles with every request raised
    rst = 1'b1;
    act_req = 4'hF; rd_req = 4'hF; wr_req = 4'hF; pre_req = 4'hF; ref_req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_gnt_c%0d", c), {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 64'h0);
      tick();
    end
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    chk("rst_cmd", {cmd_valid, cmd_type}, {1'b0, T_NOP});
    chk("rst_fields", {cmd_ba, exp_fields(1'b0, 2'd0)}, 64'h0);
    tick();
    @(negedge clk);
    chk("rel_cmd", {cmd_valid, cmd_type}, {1'b0, T_NOP});
    tick();

    // Priority and round-robin table, one row per cycle
    for (int r = 0; r < 15; r++) begin
      act_req = vecs[r].act; rd_req = vecs[r].rd; wr_req = vecs[r].wr;
      pre_req = vecs[r].pre; ref_req = vecs[r].rf;
      @(negedge clk);
      chk($sformatf("row%0d_gnt", r), {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt},
          {vecs[r].e_rf, vecs[r].e_pre, vecs[r].e_wr, vecs[r].e_rd, vecs[r].e_act});
      chk($sformatf("row%0d_cmd", r), {cmd_valid, cmd_type, cmd_ba},
          {vecs[r].e_v, vecs[r].e_t, vecs[r].e_ba});
      chk($sformatf("row%0d_fields", r), {cmd_ra, cmd_ca, cmd_id, cmd_len},
          exp_fields(vecs[r].e_v, vecs[r].e_ba));
      tick();
    end

    // ACT spacing with t_rrd_m1=2
    do_reset();
    t_rrd_m1 = 8'd2;
    act_req = 4'b1111;
    nact = 0; last = -1;
    for (int c = 0; c < 40 && nact < 4; c++) begin
      @(negedge clk);
      g = act_gnt;
      if (g != 4'b0) begin
        chk($sformatf("act_bank%0d", nact), g, 4'b0001 << nact);
        if (nact == 0) chk("act_first_cycle", c, 0);
        else chk($sformatf("act_gap%0d", nact), c - last, 3);
        last = c;
        nact++;
      end
      tick();
      act_req = act_req & ~g;
    end
    chk("act_count", nact, 4);
    clear_reqs();
    t_rrd_m1 = 8'd0;

    // Write-to-read turnaround, then wtr saturation
    for (int s = 0; s < 2; s++) begin
      do_reset();
      t_ccd_m1 = 8'd0;
      t_wtr_m1 = (s == 0) ? 8'd3 : 8'd250;
      dfi_wren_lat = (s == 0) ? 4'd2 : 4'd15;
      wr_req = 4'b0001; rd_req = 4'b0010;
      wrc = -1; rdc = -1;
      for (int c = 0; c < 400 && rdc < 0; c++) begin
        @(negedge clk);
        gw = wr_gnt; gr = rd_gnt;
        if (gw != 4'b0) begin
          chk($sformatf("ta%0d_wr_bank", s), gw, 4'b0001);
          wrc = c;
        end
        if (gr != 4'b0) begin
          chk($sformatf("ta%0d_rd_bank", s), gr, 4'b0010);
          rdc = c;
        end
        tick();
        wr_req = wr_req & ~gw;
        rd_req = rd_req & ~gr;
      end
      chk($sformatf("ta%0d_wr_cycle", s), wrc, 0);
      chk($sformatf("ta%0d_gap", s), rdc - wrc, (s == 0) ? 6 : 256);
      clear_reqs();
    end
    t_wtr_m1 = 8'd0; dfi_wren_lat = 4'd0;

    // Reset in the middle of a read-to-write window
    do_reset();
    t_rtw_m1 = 8'd5;
    rd_req = 4'b0010;
    @(negedge clk);
    chk("mr_rd_gnt", rd_gnt, 4'b0010);
    tick();
    rd_req = 4'b0000; wr_req = 4'b1001; rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_gnt", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_wr_gnt", wr_gnt, 4'b0001);
    chk("mr_cmd_after_rst", {cmd_valid, cmd_type}, {1'b0, T_NOP});
    tick();
    wr_req = 4'b1000;
    @(negedge clk);
    chk("mr_cmd_wr", {cmd_valid, cmd_type, cmd_ba}, {1'b1, T_WR, 2'd0});
    chk("mr_wr_gnt_b3", wr_gnt, 4'b1000);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("mr_cmd_wr_b3", {cmd_valid, cmd_type, cmd_ba}, {1'b1, T_WR, 2'd3});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
